// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: redirect input, imem request/response channels and
// the decode-facing output channel. The master side is the fetch stage.
interface fetch_stage_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_insn;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  out_ready,
        output imem_req_valid, imem_req_addr, imem_resp_ready,
        output out_valid, out_pc, out_insn
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output out_ready,
        input  imem_req_valid, imem_req_addr, imem_resp_ready,
        input  out_valid, out_pc, out_insn
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential imem requests under a credit
// limit of DEPTH (in flight + buffered), pairs in-order responses with their
// PCs and queues them for decode. Redirects flush the queue and mark every
// still-outstanding request to be dropped when its response returns.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] pc;

    // in-flight PC FIFO
    logic [31:0] if_pc [DEPTH];
    ptr_t        if_wr, if_rd;
    cnt_t        inflight, inflight_nxt;
    cnt_t        drop;

    // output queue of {pc, insn}
    logic [31:0] q_pc   [DEPTH];
    logic [31:0] q_insn [DEPTH];
    ptr_t        q_wr, q_rd;
    cnt_t        qcount;

    logic          req_fire, resp_fire, resp_keep, resp_drop, out_fire;
    logic [SW-1:0] credit_used;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // A response with nothing outstanding (e.g. one issued before a reset)
    // has no PC to pair with, so it is swallowed.
    assign bus.imem_resp_ready = !reset;
    assign resp_fire = bus.imem_resp_valid && bus.imem_resp_ready && (inflight != '0);
    assign resp_keep = resp_fire && (drop == '0);
    assign resp_drop = resp_fire && (drop != '0);

    assign bus.out_valid = (qcount != '0) && !bus.redirect_valid;
    assign bus.out_pc    = (qcount != '0) ? q_pc[q_rd]   : 32'h0;
    assign bus.out_insn  = (qcount != '0) ? q_insn[q_rd] : 32'h0;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Responses only move entries from in-flight to queue, so they do not
    // change the credit sum; a same-cycle dequeue frees one slot.
    assign credit_used = SW'(inflight) + SW'(qcount) - SW'(out_fire);
    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (credit_used < SW'(DEPTH));
    assign bus.imem_req_addr  = pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    // in-flight count after this cycle's request and response
    always_comb begin
        inflight_nxt = inflight;
        if (req_fire)  inflight_nxt = inflight_nxt + cnt_t'(1);
        if (resp_fire) inflight_nxt = inflight_nxt - cnt_t'(1);
    end

    // PC register: redirect wins, otherwise advance on an accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   pc <= RESET_PC;
        else if (bus.redirect_valid) pc <= bus.redirect_pc;
        else if (req_fire)           pc <= pc + 32'd4;
    end

    // in-flight FIFO pointers, count and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_wr    <= '0;
            if_rd    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            if (req_fire)  if_wr <= ptr_inc(if_wr);
            if (resp_fire) if_rd <= ptr_inc(if_rd);
            inflight <= inflight_nxt;
            // every request still outstanding after a redirect is stale
            if (bus.redirect_valid) drop <= inflight_nxt;
            else if (resp_drop)     drop <= drop - cnt_t'(1);
        end
    end

    // in-flight PC storage
    always_ff @(posedge clk) begin
        if (req_fire) if_pc[if_wr] <= pc;
    end

    // output queue pointers and occupancy; redirect flushes everything buffered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wr   <= '0;
            q_rd   <= '0;
            qcount <= '0;
        end else if (bus.redirect_valid) begin
            q_wr   <= '0;
            q_rd   <= '0;
            qcount <= '0;
        end else begin
            if (resp_keep) q_wr <= ptr_inc(q_wr);
            if (out_fire)  q_rd <= ptr_inc(q_rd);
            qcount <= qcount + cnt_t'(resp_keep) - cnt_t'(out_fire);
        end
    end

    // output queue storage
    always_ff @(posedge clk) begin
        if (resp_keep && !bus.redirect_valid) begin
            q_pc[q_wr]   <= if_pc[if_rd];
            q_insn[q_wr] <= bus.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 1-cycle-latency imem model (insn = ~addr)
// with a gate to hold responses, and hand-computed expected PC sequences.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;

    logic [31:0] pend  [$];
    logic [31:0] reqs  [$];
    logic [31:0] outs  [$];
    logic [31:0] insns [$];
    logic        resp_en;
    logic        last_req_valid;
    int          ncyc, first_req, first_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic clear_log();
        reqs.delete(); outs.delete(); insns.delete();
        first_req = -1; first_out = -1; ncyc = 0;
    endtask

    // one clock: drive response, sample at mid-cycle, advance to posedge+1
    task automatic cyc();
        logic popping;
        popping = 1'b0;
        if (resp_en && pend.size() > 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = ~pend[0];
            popping = 1'b1;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
        #1;
        last_req_valid = bus.imem_req_valid;
        if (popping) void'(pend.pop_front());
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            reqs.push_back(bus.imem_req_addr);
            pend.push_back(bus.imem_req_addr);
            if (first_req < 0) first_req = ncyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            outs.push_back(bus.out_pc);
            insns.push_back(bus.out_insn);
            if (first_out < 0) first_out = ncyc;
        end
        @(posedge clk); #1;
        ncyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        bus.out_ready      = 1'b1;
        resp_en = 1'b1;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid",  32'(bus.imem_req_valid),  32'h0);
        check("rst_resp_ready", 32'(bus.imem_resp_ready), 32'h0);
        check("rst_out_valid",  32'(bus.out_valid),       32'h0);
        check("rst_out_pc",     bus.out_pc,               32'h0);
        rst = 1'b0;
        #1;
        check("resp_ready_run", 32'(bus.imem_resp_ready), 32'h1);
        clear_log();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        @(posedge clk); #1;

        // streaming with 1-cycle imem and out_ready high
        do_reset();
        run(8);
        check("s_req0", qget(reqs, 0), 32'h0);
        check("s_req3", qget(reqs, 3), 32'hC);
        check("s_lat",  32'(first_out - first_req), 32'd2);
        check("s_out5", qget(outs, 5), 32'h14);
        check("s_insn2", qget(insns, 2), ~32'h8);

        // decode stalled: only DEPTH requests go out
        do_reset();
        bus.out_ready = 1'b0;
        run(10);
        check("st_nreq", 32'(reqs.size()), 32'd2);
        check("st_req_valid", 32'(last_req_valid), 32'h0);
        bus.out_ready = 1'b1;
        run(6);
        check("st_out0", qget(outs, 0), 32'h0);
        check("st_out1", qget(outs, 1), 32'h4);
        check("st_req2", qget(reqs, 2), 32'h8);

        // redirect with two requests outstanding
        do_reset();
        resp_en = 1'b0;
        run(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        cyc();
        check("rd_req_valid", 32'(last_req_valid), 32'h0);
        bus.redirect_valid = 1'b0;
        clear_log();
        resp_en = 1'b1;
        run(6);
        check("rd_req0",  qget(reqs, 0),  32'h100);
        check("rd_out0",  qget(outs, 0),  32'h100);
        check("rd_out1",  qget(outs, 1),  32'h104);
        check("rd_insn0", qget(insns, 0), ~32'h100);

        // back-to-back redirects
        do_reset();
        run(3);
        clear_log();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        cyc();
        bus.redirect_pc    = 32'h300;
        cyc();
        bus.redirect_valid = 1'b0;
        run(8);
        bad = 0;
        foreach (outs[i]) if (outs[i] < 32'h300) bad++;
        check("bb_stale", 32'(bad), 32'd0);
        check("bb_out0", qget(outs, 0), 32'h300);
        check("bb_out1", qget(outs, 1), 32'h304);

        // PC wrap at the top of the address space
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        cyc();
        bus.redirect_valid = 1'b0;
        clear_log();
        run(7);
        check("wr_req1", qget(reqs, 1), 32'hFFFF_FFFC);
        check("wr_req2", qget(reqs, 2), 32'h0);
        check("wr_out1", qget(outs, 1), 32'hFFFF_FFFC);
        check("wr_out2", qget(outs, 2), 32'h0);

        // reset mid-flight: one buffered, one outstanding
        do_reset();
        bus.out_ready = 1'b0;
        run(2);
        resp_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_out_valid", 32'(bus.out_valid), 32'h0);
        check("mr_out_pc",    bus.out_pc,         32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
        resp_en = 1'b1;
        bus.out_ready = 1'b1;
        run(6);
        check("mr_req0",  qget(reqs, 0),  32'h0);
        check("mr_out0",  qget(outs, 0),  32'h0);
        check("mr_insn0", qget(insns, 0), ~32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
